// File: rtl/button_click_classifier_pkg.sv
// ---------------------------------------------------------------------------
// button_click_classifier_pkg
// Shared definitions for the click classifier: the FSM state encoding and the
// default click window, which is derived from the system clock frequency.
// No ports (package).
// ---------------------------------------------------------------------------
package button_click_classifier_pkg;

  localparam int CLK_FREQ_HZ          = 20_000_000;
  localparam int WINDOW_MS            = 200;
  localparam int DEFAULT_CLICK_WINDOW = (CLK_FREQ_HZ / 1000) * WINDOW_MS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/button_click_classifier_if.sv
// ---------------------------------------------------------------------------
// button_click_classifier_if
// Bundles the press/clear inputs and the click event outputs of the
// classifier.
//   press_pulse : one-cycle press pulse from the debounce stage
//   clear       : synchronous abort of the open group
//   click_valid : one-cycle event pulse
//   click_count : clicks in the event (0 when click_valid is low)
//   busy        : a group is open
// Modports: master = the side driving presses, slave = the classifier.
// ---------------------------------------------------------------------------
interface button_click_classifier_if #(
  parameter int COUNT_W = 2
);

  logic               press_pulse;
  logic               clear;
  logic               click_valid;
  logic [COUNT_W-1:0] click_count;
  logic               busy;

  modport master (
    output press_pulse,
    output clear,
    input  click_valid,
    input  click_count,
    input  busy
  );

  modport slave (
    input  press_pulse,
    input  clear,
    output click_valid,
    output click_count,
    output busy
  );

endinterface

// File: rtl/click_gap_timer.sv
// ---------------------------------------------------------------------------
// click_gap_timer
// Restartable up-counter measuring the idle gap since the last press.
//   clk_i      : system clock
//   rst_i      : asynchronous, active-high reset
//   restart_i  : force the count back to zero (has priority over run_i)
//   run_i      : count up by one this cycle
//   expired_o  : count has reached CLICK_WINDOW-1
// ---------------------------------------------------------------------------
module click_gap_timer
  import button_click_classifier_pkg::*;
#(
  parameter int CLICK_WINDOW = DEFAULT_CLICK_WINDOW,
  parameter int TIMER_W      = 23
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic run_i,
  output logic expired_o
);

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;

  assign expired_o = (timer_q == TIMER_W'(CLICK_WINDOW - 1));

  // Counting stops at the expiry value so the timer can never run past it.
  always_comb begin
    timer_d = timer_q;
    if (restart_i) begin
      timer_d = '0;
    end else if (run_i && !expired_o) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/button_click_classifier.sv
// ---------------------------------------------------------------------------
// button_click_classifier
// Groups debounced press pulses that fall within CLICK_WINDOW idle cycles of
// each other into one click event, reported as a one-cycle click_valid pulse
// with the number of clicks. A group closes early once MAX_CLICKS presses
// have been collected.
//   CLK   : system clock
//   RESET : asynchronous, active-high reset; drops any open group
//   bus   : button_click_classifier_if.slave (press_pulse, clear in;
//           click_valid, click_count, busy out, all registered)
// ---------------------------------------------------------------------------
module button_click_classifier
  import button_click_classifier_pkg::*;
#(
  parameter int CLICK_WINDOW = DEFAULT_CLICK_WINDOW,
  parameter int MAX_CLICKS   = 3,
  parameter int COUNT_W      = 2,
  parameter int TIMER_W      = 23
) (
  input  logic                          CLK,
  input  logic                          RESET,
  button_click_classifier_if.slave      bus
);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               clickValid_q, clickValid_d;
  logic [COUNT_W-1:0] clickCount_q, clickCount_d;
  logic               busy_q, busy_d;

  logic [COUNT_W:0]   countInc;
  logic               timerRestart;
  logic               timerRun;
  logic               timerExpired;

  // One extra bit so the comparison against MAX_CLICKS cannot wrap.
  assign countInc = {1'b0, count_q} + 1'b1;

  // The window restarts on every press and is held at zero outside COLLECT,
  // so a new group always starts from a fresh window.
  assign timerRestart = bus.clear || bus.press_pulse || (state_q != COLLECT);
  assign timerRun     = (state_q == COLLECT);

  click_gap_timer #(
    .CLICK_WINDOW (CLICK_WINDOW),
    .TIMER_W      (TIMER_W)
  ) u_gapTimer (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .restart_i (timerRestart),
    .run_i     (timerRun),
    .expired_o (timerExpired)
  );

  // Next-state logic. clear dominates everything; in COLLECT a press beats a
  // simultaneous window expiry; a press during REPORT opens the next group.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.press_pulse) begin
            count_d = COUNT_W'(1);
            state_d = (MAX_CLICKS == 1) ? REPORT : COLLECT;
          end
        end
        COLLECT: begin
          if (bus.press_pulse) begin
            count_d = countInc[COUNT_W-1:0];
            state_d = (countInc == (COUNT_W + 1)'(MAX_CLICKS)) ? REPORT : COLLECT;
          end else if (timerExpired) begin
            state_d = REPORT;
          end
        end
        REPORT: begin
          if (bus.press_pulse) begin
            count_d = COUNT_W'(1);
            state_d = (MAX_CLICKS == 1) ? REPORT : COLLECT;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end
        default: begin
          count_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so that they appear, registered,
  // in the same cycle the FSM is in REPORT.
  always_comb begin
    clickValid_d = (state_d == REPORT);
    clickCount_d = (state_d == REPORT) ? count_d : '0;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      count_q      <= '0;
      clickValid_q <= 1'b0;
      clickCount_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      clickValid_q <= clickValid_d;
      clickCount_q <= clickCount_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.click_valid = clickValid_q;
  assign bus.click_count = clickCount_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_button_click_classifier.sv
// ---------------------------------------------------------------------------
// tb_button_click_classifier
// Self-checking bench for button_click_classifier with CLICK_WINDOW=10,
// MAX_CLICKS=3. Cycle 0 is the first cycle after reset release; an input
// driven in cycle c is sampled at the edge ending cycle c, and registered
// outputs "in cycle c" are those visible during cycle c.
// ---------------------------------------------------------------------------
module tb_button_click_classifier;

  localparam int CLICK_WINDOW = 10;
  localparam int MAX_CLICKS   = 3;
  localparam int COUNT_W      = 2;
  localparam int TIMER_W      = 4;
  localparam int NCYC         = 41;
  localparam int NVEC         = 10;

  typedef struct {
    logic [63:0] pressMask;
    int          resetCyc;
    int          clearCyc;
    int          ev0Cyc;
    int          ev0Cnt;
    int          ev1Cyc;
    int          ev1Cnt;
    int          busyLo;
    int          busyHi;
  } vec_t;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;
  vec_t vecs[NVEC];
  exp_t sbq[$];

  button_click_classifier_if #(.COUNT_W(COUNT_W)) bus ();

  button_click_classifier #(
    .CLICK_WINDOW (CLICK_WINDOW),
    .MAX_CLICKS   (MAX_CLICKS),
    .COUNT_W      (COUNT_W),
    .TIMER_W      (TIMER_W)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [63:0] bitAt(input int c);
    logic [63:0] one;
    one = 64'd1;
    return one << c;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic press, input logic clr, input logic rst);
    bus.press_pulse = press;
    bus.clear       = clr;
    RESET           = rst;
  endtask

  task automatic checkOutput(input string name, input int scen, input int cyc,
                             input int got, input int expected);
    checks++;
    if (got != expected) begin
      errors++;
      $display("[TB] FAIL %s: scenario %0d cycle %0d got %0d expected %0d",
               name, scen, cyc, got, expected);
    end
  endtask

  // Holds reset for two edges; returns at the start of cycle 0.
  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (2) step();
  endtask

  // Scoreboard check of one cycle: events are popped when the DUT pulses.
  task automatic checkCycle(input int s, input int c, input vec_t v);
    exp_t e;
    if (bus.click_valid) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpectedEvent", s, c, 1, 0);
      end else begin
        e = sbq.pop_front();
        checkOutput("eventCycle", s, c, c, e.cyc);
        checkOutput("eventCount", s, c, int'(bus.click_count), e.cnt);
      end
    end else begin
      checkOutput("idleCount", s, c, int'(bus.click_count), 0);
    end
    checkOutput("busy", s, c, int'(bus.busy), (c >= v.busyLo && c <= v.busyHi) ? 1 : 0);
  endtask

  task automatic runScenario(input int s);
    vec_t v;
    exp_t e;
    v = vecs[s];
    sbq.delete();
    doReset();
    if (v.ev0Cyc >= 0) begin
      e.cyc = v.ev0Cyc; e.cnt = v.ev0Cnt; sbq.push_back(e);
    end
    if (v.ev1Cyc >= 0) begin
      e.cyc = v.ev1Cyc; e.cnt = v.ev1Cnt; sbq.push_back(e);
    end
    for (int c = 0; c < NCYC; c++) begin
      applyStimulus(v.pressMask[c], (c == v.clearCyc), (c == v.resetCyc));
      #4;
      checkCycle(s, c, v);
      step();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("missingEvent", s, e.cyc, 0, 1);
    end
  endtask

  // Presses in nPress consecutive cycles starting at cycle 3, then a bounded
  // wait for the event; latency is counted from the last press.
  task automatic measureLatency(input int id, input int nPress,
                                input int expLat, input int expCnt);
    int found;
    doReset();
    for (int c = 0; c < 3 + nPress; c++) begin
      applyStimulus((c >= 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      step();
    end
    found = 0;
    for (int k = 1; k <= 30 && found == 0; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      #4;
      if (bus.click_valid) begin
        found = 1;
        checkOutput("latency", id, k, k, expLat);
        checkOutput("latencyCount", id, k, int'(bus.click_count), expCnt);
      end
      step();
    end
    if (found == 0) begin
      checkOutput("latencyTimeout", id, 30, 0, 1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.press_pulse = 1'b0;
    bus.clear       = 1'b0;
    RESET           = 1'b1;

    // Fields: pressMask, resetCyc, clearCyc, ev0Cyc, ev0Cnt, ev1Cyc, ev1Cnt, busyLo, busyHi
    vecs[0] = '{bitAt(5), -1, -1, 16, 1, -1, 0, 6, 16};
    vecs[1] = '{bitAt(5) | bitAt(9), -1, -1, 20, 2, -1, 0, 6, 20};
    vecs[2] = '{bitAt(5) | bitAt(8) | bitAt(11), -1, -1, 12, 3, -1, 0, 6, 12};
    vecs[3] = '{bitAt(5) | bitAt(15), -1, -1, 26, 2, -1, 0, 6, 26};
    vecs[4] = '{bitAt(5), 9, -1, -1, 0, -1, 0, 6, 8};
    vecs[5] = '{bitAt(5), -1, 9, -1, 0, -1, 0, 6, 9};
    vecs[6] = '{bitAt(5) | bitAt(16), -1, -1, 16, 1, 27, 1, 6, 27};
    vecs[7] = '{bitAt(5), -1, 5, -1, 0, -1, 0, 0, -1};
    vecs[8] = '{bitAt(5) | bitAt(7) | bitAt(9) | bitAt(10) | bitAt(12) | bitAt(14),
                -1, -1, 10, 3, 15, 3, 6, 15};
    vecs[9] = '{bitAt(5) | bitAt(8) | bitAt(11) | bitAt(12), -1, 12, 12, 3, -1, 0, 6, 12};

    // Reset state while RESET is held.
    @(posedge CLK);
    #2;
    checkOutput("resetValid", -1, 0, int'(bus.click_valid), 0);
    checkOutput("resetCount", -1, 0, int'(bus.click_count), 0);
    checkOutput("resetBusy", -1, 0, int'(bus.busy), 0);

    for (int s = 0; s < NVEC; s++) begin
      runScenario(s);
    end

    measureLatency(100, 1, CLICK_WINDOW + 1, 1);
    measureLatency(101, 2, CLICK_WINDOW + 1, 2);
    measureLatency(102, 3, 1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_click_classifier.md
Name: button_click_classifier

Overview:
Sits directly downstream of the switch debounce/edge-detect stage. It consumes that stage's one-cycle press pulses and groups presses that fall within a configurable time window into single-, double- or N-click events. It emits one event pulse per group, carrying the click count, to the mode/control FSMs.

Parameters:
CLICK_WINDOW, 4_000_000, idle gap in CLK cycles after the last press that closes a group (200 ms at 20 MHz); must be >= 2
MAX_CLICKS, 3, click count at which a group closes immediately, without waiting for the window; 1..2^COUNT_W-1
COUNT_W, 2, width of click_count
TIMER_W, 23, width of the gap timer; must hold CLICK_WINDOW-1

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
press_pulse  input  1  one-cycle press pulse from the debounce stage
clear  input  1  synchronous abort; discards the open group without reporting it
click_valid  output  1  one-cycle pulse; an event is reported this cycle
click_count  output  COUNT_W  number of clicks in the event; valid only while click_valid=1, 0 otherwise
busy  output  1  high while a group is open (state COLLECT or REPORT)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, count=0, timer=0, click_valid=0, click_count=0, busy=0. Reset asserted mid-group drops the group silently.
- All outputs are registered.
- States: IDLE, COLLECT, REPORT.
- IDLE:
  - press_pulse -> count<=1, timer<=0, go to COLLECT.
  - If MAX_CLICKS==1, go to REPORT instead.
- COLLECT, press_pulse:
  - count<=count+1, timer<=0.
  - If count+1==MAX_CLICKS, go to REPORT; otherwise stay in COLLECT.
- COLLECT, no press:
  - timer<=timer+1.
  - When timer==CLICK_WINDOW-1, go to REPORT instead.
- COLLECT, press in the same cycle as timer==CLICK_WINDOW-1: the press wins. The count increments and the window restarts.
- REPORT (exactly one cycle): click_valid=1, click_count=count. Next state is IDLE.
  - A press_pulse arriving in the REPORT cycle is not lost. Next state is COLLECT with count=1, timer=0 (or REPORT again if MAX_CLICKS==1).
- Timeout latency: last press in cycle t -> click_valid high in cycle t+CLICK_WINDOW+1.
- MAX_CLICKS latency: the press that completes the group in cycle t -> click_valid high in cycle t+1.
- clear: highest priority after RESET. In any state it forces IDLE with count=0, timer=0, click_valid=0 next cycle. A press in the same cycle as clear is discarded.
- The count never exceeds MAX_CLICKS, so no wrap-around. The timer never passes CLICK_WINDOW-1.
- busy=1 in COLLECT and REPORT, 0 in IDLE.

Decomposition:
- Shared package: state encoding enum (IDLE=2'd0, COLLECT=2'd1, REPORT=2'd2) and the default CLICK_WINDOW constant tied to the system clock frequency.
- One natural sub-module, click_gap_timer: a restartable up-counter with inputs restart and run, and output expired when the count reaches CLICK_WINDOW-1. The FSM and count register stay in the top module.

Test Plan (CLICK_WINDOW=10, MAX_CLICKS=3):
- Single press in cycle 5 -> click_valid=1 with click_count=1 in cycle 16 only; busy high cycles 6..16.
- Presses in cycles 5 and 9 -> click_valid with click_count=2 in cycle 20; no pulse in cycle 16.
- Presses in cycles 5, 8 and 11 -> click_valid with click_count=3 in cycle 12; no timeout event follows.
- Press in cycle 5, second press in cycle 15 (timer==9, collision) -> group extends; click_count=2 in cycle 26.
- Press in cycle 5, RESET pulse in cycle 9 (or clear in cycle 9) -> no click_valid through cycle 40; outputs 0 from the reset/clear point.
- Press in cycle 5, another press in cycle 16 (the REPORT cycle) -> count=1 reported in cycle 16, then a new count=1 event in cycle 27.
